// File: rtl/capture_readout_pkg.sv
// -----------------------------------------------------------------------------
// capture_readout_pkg
// Shared definitions for the capture buffer readout engine: default widths,
// FSM state encoding and the words-per-sample helper.
// -----------------------------------------------------------------------------
package capture_readout_pkg;

   localparam int DEF_DATA_WIDTH = 72;
   localparam int DEF_ADDR_WIDTH = 12;
   localparam int DEF_WORD_WIDTH = 32;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_READ   = 3'd1,
      ST_WAIT   = 3'd2,
      ST_SEND   = 3'd3,
      ST_FINISH = 3'd4
   } state_t;

   // Number of host words needed to carry one sample (ceiling division).
   function automatic int calc_wps(input int data_width, input int word_width);
      return (data_width + word_width - 1) / word_width;
   endfunction

   // Width of the word index; never narrower than one bit.
   function automatic int calc_idx_width(input int wps);
      return (wps > 1) ? $clog2(wps) : 1;
   endfunction

endpackage

// File: rtl/capture_word_mux.sv
// -----------------------------------------------------------------------------
// capture_word_mux
// Combinational slicer: picks word i_index out of a sample, least-significant
// word first. The topmost word is zero-padded above the sample MSB.
// Ports:
//   i_sample  sample to slice (DATA_WIDTH)
//   i_index   word index 0..WPS-1 (IDX_W)
//   o_word    selected word (WORD_WIDTH); zero for an out-of-range index
// -----------------------------------------------------------------------------
module capture_word_mux
   import capture_readout_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int WORD_WIDTH = DEF_WORD_WIDTH,
   parameter int WPS        = calc_wps(DATA_WIDTH, WORD_WIDTH),
   parameter int IDX_W      = calc_idx_width(WPS)
)(
   input  logic [DATA_WIDTH-1:0] i_sample,
   input  logic [IDX_W-1:0]      i_index,
   output logic [WORD_WIDTH-1:0] o_word
);

   logic [WPS*WORD_WIDTH-1:0] w_padded;
   logic [WORD_WIDTH-1:0]     w_words [WPS];

   always_comb begin
      w_padded                 = '0;
      w_padded[DATA_WIDTH-1:0] = i_sample;
   end

   genvar gi;
   generate
      for (gi = 0; gi < WPS; gi++) begin : g_slice
         assign w_words[gi] = w_padded[gi*WORD_WIDTH +: WORD_WIDTH];
      end
   endgenerate

   always_comb begin
      o_word = '0;
      for (int i = 0; i < WPS; i++) begin
         if (i_index == IDX_W'(i)) begin
            o_word = w_words[i];
         end
      end
   end

endmodule

// File: rtl/capture_readout.sv
// -----------------------------------------------------------------------------
// capture_readout
// Streams a finished capture out of an external buffer to the host, one
// sample at a time, as WPS words per sample over a valid/ready handshake.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   clk_enable          low freezes all state and outputs
//   start               host readout request (honoured only in idle)
//   capture_done        buffer holds a finished capture
//   sample_count        stored samples, 0..2^ADDR_WIDTH
//   mem_rd_en/mem_addr  buffer read strobe and address
//   mem_rdata           buffer data, valid one cycle after mem_rd_en
//   o_word/o_valid      host word and its valid
//   o_ready             host accepts the word
//   o_last              final word of the readout
//   busy/done           readout active / one-cycle completion pulse
// -----------------------------------------------------------------------------
module capture_readout
   import capture_readout_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int WORD_WIDTH = DEF_WORD_WIDTH
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clk_enable,
   input  logic                  start,
   input  logic                  capture_done,
   input  logic [ADDR_WIDTH:0]   sample_count,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [WORD_WIDTH-1:0] o_word,
   output logic                  o_valid,
   input  logic                  o_ready,
   output logic                  o_last,
   output logic                  busy,
   output logic                  done
);

   localparam int WPS   = calc_wps(DATA_WIDTH, WORD_WIDTH);
   localparam int IDX_W = calc_idx_width(WPS);

   localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(WPS - 1);
   localparam logic [IDX_W-1:0]      IDX_ONE  = IDX_W'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);

   state_t                  r_state;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [ADDR_WIDTH-1:0]   r_last_addr;
   logic [DATA_WIDTH-1:0]   r_sample;
   logic [IDX_W-1:0]        r_idx;
   logic                    r_rd_en;
   logic                    r_valid;
   logic                    r_last;
   logic                    r_busy;
   logic                    r_done;

   logic [ADDR_WIDTH:0]     w_count_m1;
   logic                    w_zero_count;
   logic                    w_is_last_sample;
   logic                    w_transfer;
   logic [WORD_WIDTH-1:0]   w_word;

   // Latching count-1 as an ADDR_WIDTH value lets a full buffer
   // (2^ADDR_WIDTH samples) end at the top address without wrapping.
   assign w_count_m1       = sample_count - CNT_ONE;
   assign w_zero_count     = (sample_count == '0);
   assign w_is_last_sample = (r_addr == r_last_addr);
   assign w_transfer       = r_valid & o_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_addr      <= '0;
         r_last_addr <= '0;
         r_sample    <= '0;
         r_idx       <= '0;
         r_rd_en     <= 1'b0;
         r_valid     <= 1'b0;
         r_last      <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else if (clk_enable) begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (start && capture_done) begin
                  r_busy <= 1'b1;
                  r_addr <= '0;
                  if (w_zero_count) begin
                     r_done  <= 1'b1;
                     r_state <= ST_FINISH;
                  end else begin
                     r_last_addr <= w_count_m1[ADDR_WIDTH-1:0];
                     r_rd_en     <= 1'b1;
                     r_state     <= ST_READ;
                  end
               end
            end
            ST_READ: begin
               r_rd_en <= 1'b0;
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               // Read data is valid in this cycle, one after the strobe.
               r_sample <= mem_rdata;
               r_idx    <= '0;
               r_valid  <= 1'b1;
               r_last   <= (WPS == 1) && w_is_last_sample;
               r_state  <= ST_SEND;
            end
            ST_SEND: begin
               if (w_transfer) begin
                  if (r_idx == LAST_IDX) begin
                     r_valid <= 1'b0;
                     r_last  <= 1'b0;
                     if (w_is_last_sample) begin
                        r_done  <= 1'b1;
                        r_state <= ST_FINISH;
                     end else begin
                        r_addr  <= r_addr + ADDR_ONE;
                        r_rd_en <= 1'b1;
                        r_state <= ST_READ;
                     end
                  end else begin
                     r_idx  <= r_idx + IDX_ONE;
                     r_last <= ((r_idx + IDX_ONE) == LAST_IDX) && w_is_last_sample;
                  end
               end
            end
            ST_FINISH: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Word is sliced from registered sample/index, so it stays stable
   // through a stall and reads zero after reset.
   capture_word_mux #(
      .DATA_WIDTH (DATA_WIDTH),
      .WORD_WIDTH (WORD_WIDTH),
      .WPS        (WPS),
      .IDX_W      (IDX_W)
   ) u_word_mux (
      .i_sample (r_sample),
      .i_index  (r_idx),
      .o_word   (w_word)
   );

   assign mem_rd_en = r_rd_en;
   assign mem_addr  = r_addr;
   assign o_word    = w_word;
   assign o_valid   = r_valid;
   assign o_last    = r_last;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

// File: tb/tb_capture_readout.sv
// -----------------------------------------------------------------------------
// tb_capture_readout
// Self-checking bench: a queue-based reference model of the expected word
// stream is built from the buffer contents, and a negedge monitor compares
// every handshake, read address and status pulse against it.
// -----------------------------------------------------------------------------
module tb_capture_readout;

   localparam int DW  = 72;
   localparam int AW  = 12;
   localparam int WW  = 32;
   localparam int WPS = (DW + WW - 1) / WW;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          reset;
   logic          clk_enable;
   logic          start;
   logic          capture_done;
   logic [AW:0]   sample_count;
   logic          mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rdata = '0;
   logic [WW-1:0] o_word;
   logic          o_valid;
   logic          o_ready;
   logic          o_last;
   logic          busy;
   logic          done;

   always #5 clk = ~clk;

   capture_readout #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .WORD_WIDTH (WW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .clk_enable   (clk_enable),
      .start        (start),
      .capture_done (capture_done),
      .sample_count (sample_count),
      .mem_rd_en    (mem_rd_en),
      .mem_addr     (mem_addr),
      .mem_rdata    (mem_rdata),
      .o_word       (o_word),
      .o_valid      (o_valid),
      .o_ready      (o_ready),
      .o_last       (o_last),
      .busy         (busy),
      .done         (done)
   );

   function automatic logic [DW-1:0] rand_sample();
      return {8'($urandom()), $urandom(), $urandom()};
   endfunction

   // External buffer: one-cycle read latency, garbage when not strobed so a
   // mistimed capture of read data shows up as a wrong word.
   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (clk_enable) begin
         mem_rdata <= mem_rd_en ? mem[mem_addr] : rand_sample();
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- monitor / scoreboard ----------------
   logic [WW-1:0] exp_words [$];
   logic [WW-1:0] got_words [$];
   bit            mon_en = 1'b0;
   int            widx, rd_count, last_count, done_count, max_addr;
   int            mon_cyc, done_cyc, last_word_cyc;
   bit            done_seen;
   bit            prev_stall;
   logic [WW-1:0] prev_word;
   logic          prev_last;

   always @(negedge clk) begin
      if (mon_en) begin
         if (prev_stall) begin
            check_value("stall_valid", o_valid, 1'b1);
            check_value("stall_word", o_word, prev_word);
            check_value("stall_last", o_last, prev_last);
         end
         if (o_last && !o_valid) check_value("last_without_valid", o_valid, 1'b1);
         if (clk_enable) begin
            if (mem_rd_en) begin
               check_value("rd_addr", mem_addr, rd_count);
               rd_count++;
               if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
            end
            if (o_valid && o_ready) begin
               if (widx < exp_words.size()) begin
                  check_value("word", o_word, exp_words[widx]);
                  check_value("last_flag", o_last, widx == exp_words.size() - 1);
               end else begin
                  check_value("extra_word", widx + 1, exp_words.size());
               end
               got_words.push_back(o_word);
               if (o_last) last_count++;
               last_word_cyc = mon_cyc;
               widx++;
            end
            if (done) begin
               done_count++;
               if (!done_seen) done_cyc = mon_cyc;
               done_seen = 1'b1;
            end
         end
         prev_stall = o_valid && !(o_ready && clk_enable);
         prev_word  = o_word;
         prev_last  = o_last;
         mon_cyc++;
      end
   end

   task automatic check_reset_state(input string tag);
      check_value({tag, "_rd_en"}, mem_rd_en, 1'b0);
      check_value({tag, "_addr"},  mem_addr,  '0);
      check_value({tag, "_word"},  o_word,    '0);
      check_value({tag, "_valid"}, o_valid,   1'b0);
      check_value({tag, "_last"},  o_last,    1'b0);
      check_value({tag, "_busy"},  busy,      1'b0);
      check_value({tag, "_done"},  done,      1'b0);
   endtask

   // One readout: rmode 0 = ready high, 1 = ready toggling 1010..,
   // 2 = random ready. jitter adds clk_enable gaps, stray starts and
   // post-acceptance changes to sample_count/capture_done.
   task automatic run_readout(input int count, input int rmode, input bit jitter, input bit preset);
      int cyc;
      int bound;
      logic [DW-1:0] t;
      if (!preset) for (int s = 0; s < count; s++) mem[s] = rand_sample();
      exp_words.delete();
      got_words.delete();
      for (int s = 0; s < count; s++) begin
         for (int w = 0; w < WPS; w++) begin
            t = mem[s] >> (WW * w);
            exp_words.push_back(t[WW-1:0]);
         end
      end
      widx = 0; rd_count = 0; last_count = 0; done_count = 0; max_addr = -1;
      done_seen = 1'b0; prev_stall = 1'b0; done_cyc = -1; last_word_cyc = -1;
      reset        = 1'b0;
      clk_enable   = 1'b1;
      sample_count = (AW+1)'(count);
      capture_done = 1'b1;
      o_ready      = 1'b1;
      start        = 1'b1;
      tick();
      start   = 1'b0;
      mon_cyc = 0;
      mon_en  = 1'b1;
      if (jitter) begin
         sample_count = (AW+1)'($urandom_range(0, DEPTH));
         capture_done = 1'($urandom_range(0, 1));
      end
      cyc   = 0;
      bound = 2000 + count * 50;
      while (!done_seen && cyc < bound) begin
         case (rmode)
            0:       o_ready = 1'b1;
            1:       o_ready = (cyc % 2 == 0);
            default: o_ready = 1'($urandom_range(0, 1));
         endcase
         if (jitter) begin
            clk_enable = ($urandom_range(0, 4) != 0);
            start      = 1'($urandom_range(0, 1));
         end
         tick();
         cyc++;
      end
      clk_enable = 1'b1;
      start      = 1'b0;
      o_ready    = 1'b1;
      check_value("done_seen", done_seen, 1'b1);
      tick();
      tick();
      mon_en = 1'b0;
      check_value("word_count", widx, count * WPS);
      check_value("last_count", last_count, (count > 0) ? 1 : 0);
      check_value("read_count", rd_count, count);
      check_value("done_pulses", done_count, 1);
      check_value("busy_after", busy, 1'b0);
      if (count > 0) check_value("max_addr", max_addr, count - 1);
      if (!jitter && rmode == 0) begin
         check_value("done_cycle", done_cyc, count * (2 + WPS));
         if (count > 0) check_value("done_after_last", done_cyc, last_word_cyc + 1);
      end
      $display("readout count=%0d ready_mode=%0d jitter=%0d words=%0d done_cycle=%0d",
               count, rmode, jitter, widx, done_cyc);
   endtask

   initial begin
      bit found;
      reset        = 1'b1;
      clk_enable   = 1'b1;
      start        = 1'b0;
      capture_done = 1'b0;
      sample_count = '0;
      o_ready      = 1'b0;
      repeat (3) tick();
      check_reset_state("por");
      reset = 1'b0;
      tick();

      // Directed two-sample readout, ready high then toggling.
      mem[0] = 72'h11_22223333_44445555;
      mem[1] = 72'hAA_BBBBCCCC_DDDDEEEE;
      for (int m = 0; m < 2; m++) begin
         run_readout(2, m, 1'b0, 1'b1);
         if (got_words.size() == 6) begin
            check_value("dir_word0", got_words[0], 32'h44445555);
            check_value("dir_word2", got_words[2], 32'h00000011);
            check_value("dir_word5", got_words[5], 32'h000000AA);
         end
      end

      // start without a finished capture is ignored.
      capture_done = 1'b0;
      sample_count = (AW+1)'(5);
      start        = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check_value("nocap_busy", busy, 1'b0);
         check_value("nocap_rd_en", mem_rd_en, 1'b0);
      end
      start = 1'b0;
      $display("readout ignored without capture_done");

      // Empty capture: done pulse only.
      run_readout(0, 0, 1'b0, 1'b1);

      // Randomized readouts.
      for (int r = 0; r < 8; r++) run_readout($urandom_range(1, 20), $urandom_range(0, 2), 1'b1, 1'b0);
      for (int r = 0; r < 3; r++) run_readout($urandom_range(1, 20), 2, 1'b0, 1'b0);

      // Reset while sending sample 1.
      for (int s = 0; s < 3; s++) mem[s] = rand_sample();
      sample_count = (AW+1)'(3);
      capture_done = 1'b1;
      o_ready      = 1'b1;
      start        = 1'b1;
      tick();
      start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         if (o_valid && mem_addr == AW'(1)) found = 1'b1;
         else tick();
      end
      check_value("reach_sample1", found, 1'b1);
      reset = 1'b1;
      tick();
      check_reset_state("mid_reset");
      reset = 1'b0;
      $display("reset applied during sample 1");
      run_readout(3, 0, 1'b0, 1'b1);

      // Full buffer.
      run_readout(DEPTH, 0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/capture_readout.md
CAPTURE_READOUT -- requirements
Module: capture_readout

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 72, captured sample width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, capture buffer address width.
REQ-003 SHALL have parameter WORD_WIDTH, default 32, host transfer word width.
REQ-004 SHALL have port clk, input, 1, the single clock; reset is synchronous and active-high.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port clk_enable, input, 1; low freezes all state and outputs.
REQ-007 SHALL have port start, input, 1, host readout request.
REQ-008 SHALL have port capture_done, input, 1, level from the capture side meaning the buffer holds a finished capture.
REQ-009 SHALL have port sample_count, input, ADDR_WIDTH+1, number of stored samples, 0..2^ADDR_WIDTH.
REQ-010 SHALL have port mem_rd_en, output, 1, buffer read strobe.
REQ-011 SHALL have port mem_addr, output, ADDR_WIDTH, buffer read address.
REQ-012 SHALL have port mem_rdata, input, DATA_WIDTH, buffer data, valid exactly one cycle after mem_rd_en.
REQ-013 SHALL have port o_word, output, WORD_WIDTH, host data word.
REQ-014 SHALL have port o_valid, output, 1, o_word valid.
REQ-015 SHALL have port o_ready, input, 1, host accepts word.
REQ-016 SHALL have port o_last, output, 1, marks final word of the readout.
REQ-017 SHALL have ports busy and done, output, 1 each: readout active; one-cycle completion pulse.

Function
REQ-018 SHALL use WPS = ceil(DATA_WIDTH/WORD_WIDTH) words per sample (3 at defaults); the top word is zero-padded above bit DATA_WIDTH-1.
REQ-019 SHALL implement FSM states IDLE, READ, WAIT, SEND, FINISH.
REQ-020 IDLE->READ when start=1 and capture_done=1 and sample_count>0; address counter cleared to 0.
REQ-021 IDLE->FINISH when start=1, capture_done=1 and sample_count=0; no words emitted.
REQ-022 start with capture_done=0, or start in any state other than IDLE, SHALL be ignored.
REQ-023 READ: assert mem_rd_en for one cycle at mem_addr; go to WAIT.
REQ-024 WAIT: register mem_rdata into a DATA_WIDTH sample register; go to SEND with word index 0.
REQ-025 SEND: o_valid=1, o_word = sample slice for index i, least-significant word first.
REQ-026 A word transfers on o_valid&o_ready; o_word, o_last SHALL hold stable while o_valid=1 and o_ready=0.
REQ-027 After transfer of index WPS-1: if the address is the last sample (sample_count-1) go to FINISH, else increment the address and go to READ.
REQ-028 o_last SHALL be 1 only with the final word (index WPS-1 of sample sample_count-1).
REQ-029 FINISH: done=1 for exactly one cycle, then IDLE.
REQ-030 busy SHALL be 1 in READ, WAIT, SEND, FINISH.
REQ-031 sample_count=2^ADDR_WIDTH SHALL read all addresses 0..2^ADDR_WIDTH-1 without address wrap before completion.
REQ-032 sample_count and capture_done SHALL be sampled at start acceptance; later changes SHALL not affect the run.
REQ-033 The minimum sample period SHALL be 2+WPS cycles with o_ready held high; there SHALL be no throughput beyond this.

Reset
REQ-034 reset SHALL take precedence over clk_enable and force IDLE in the same clock edge, including mid-readout.
REQ-035 After reset: mem_rd_en=0, mem_addr=0, o_word=0, o_valid=0, o_last=0, busy=0, done=0; sample register and counters=0.

Structure
REQ-036 The FSM state encoding and WPS computation SHALL live in a shared package (capture_readout_pkg) with the DATA/ADDR/WORD width defaults.
REQ-037 The word slicing/padding SHALL be a sub-module capture_word_mux (sample, index -> word), combinational.
REQ-038 Memory SHALL be external; this block only issues reads.

Verification
REQ-039 sample_count=2, samples 0x11_22223333_44445555, 0xAA_BBBBCCCC_DDDDEEEE, o_ready=1 -> words 44445555, 22223333, 00000011, DDDDEEEE, BBBBCCCC, 000000AA; o_last on word 6; done 1 cycle later.
REQ-040 Same stimulus, o_ready toggled 1010... -> identical word sequence, o_word stable during stalls.
REQ-041 start with capture_done=0 -> busy stays 0, no mem_rd_en.
REQ-042 sample_count=0, start -> done pulse, no o_valid.
REQ-043 sample_count=4096 -> 12288 words, last mem_addr 0xFFF, o_last once.
REQ-044 reset asserted during SEND of sample 1 -> next cycle all outputs at reset values; new start restarts from address 0.
